// File: rtl/ex_mul_issue.sv
// ----------------------------------------------------------------------------
// ex_mul_issue
//
// EX-stage issue/hold controller that sits directly in front of a multi-cycle
// multiplier. It takes one instruction at a time from ID. A mul op is launched
// and held stable on the multiplier inputs until mul_done, and the result is
// then captured. Any other op passes its ALU result straight through. In both
// cases the result is offered to MEM.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds its payload stable while valid && !ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               kill the in-flight instruction (ignored in DRAIN)
//   id_valid/id_ready   ID handshake; id_ready = IDLE && !flush
//   id_op, id_src_a/b   opcode and multiplier operands
//   id_alu_res, id_rd   non-mul result and destination register
//   mul_op, mul_a/b     multiplier launch (op is OP_NOP outside BUSY)
//   mul_done/mul_result multiplier completion pulse and result
//   mem_valid/mem_ready MEM handshake
//   mem_result, mem_rd  registered result and destination register
//
// Optional feature (macro EX_MUL_PERF_EN): adds perf_mul_cnt (mul results
// captured) and perf_stall_cnt (cycles with id_valid && !id_ready) outputs.
// ----------------------------------------------------------------------------
module ex_mul_issue #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_W     = 5,
    // Opcode encoding shared with the decoder
    parameter logic [7:0]  OP_NOP   = 8'h00,
    parameter logic [7:0]  OP_MUL   = 8'h30,
    parameter logic [7:0]  OP_MULH  = 8'h31,
    parameter logic [7:0]  OP_MULHU = 8'h33
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [7:0]        id_op,
    input  logic [DATA_W-1:0] id_src_a,
    input  logic [DATA_W-1:0] id_src_b,
    input  logic [DATA_W-1:0] id_alu_res,
    input  logic [RD_W-1:0]   id_rd,
    output logic [7:0]        mul_op,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic              mul_done,
    input  logic [DATA_W-1:0] mul_result,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_result,
    output logic [RD_W-1:0]   mem_rd
`ifdef EX_MUL_PERF_EN
    ,
    output logic [31:0]       perf_mul_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          mul_op_q, mul_op_d;
    logic [DATA_W-1:0]   mul_a_q, mul_a_d;
    logic [DATA_W-1:0]   mul_b_q, mul_b_d;
    logic                mem_valid_q, mem_valid_d;
    logic [DATA_W-1:0]   mem_result_q, mem_result_d;
    logic [RD_W-1:0]     mem_rd_q, mem_rd_d;
    logic                accept;
    logic                id_is_mul;

    assign id_ready  = (state_q == S_IDLE) && !flush;
    assign accept    = id_valid && id_ready;
    assign id_is_mul = (id_op == OP_MUL) || (id_op == OP_MULH) || (id_op == OP_MULHU);

    always_comb begin
        state_d      = state_q;
        mul_op_d     = mul_op_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mem_valid_d  = mem_valid_q;
        mem_result_d = mem_result_q;
        mem_rd_d     = mem_rd_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mul_a_d  = id_src_a;
                    mul_b_d  = id_src_b;
                    mem_rd_d = id_rd;
                    if (id_is_mul) begin
                        mul_op_d = id_op;
                        state_d  = S_BUSY;
                    end else begin
                        mem_result_d = id_alu_res;
                        mem_valid_d  = 1'b1;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    // The multiplier must finish before the next launch; if it
                    // is finishing right now there is nothing left to wait for.
                    mul_op_d = OP_NOP;
                    state_d  = mul_done ? S_IDLE : S_DRAIN;
                end else if (mul_done) begin
                    mul_op_d     = OP_NOP;
                    mem_result_d = mul_result;
                    mem_valid_d  = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (mem_ready || flush) begin
                    mem_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mul_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mul_op_q     <= OP_NOP;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mem_valid_q  <= 1'b0;
            mem_result_q <= '0;
            mem_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            mul_op_q     <= mul_op_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mem_valid_q  <= mem_valid_d;
            mem_result_q <= mem_result_d;
            mem_rd_q     <= mem_rd_d;
        end
    end

    assign mul_op     = mul_op_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mem_valid  = mem_valid_q;
    assign mem_result = mem_result_q;
    assign mem_rd     = mem_rd_q;

`ifdef EX_MUL_PERF_EN
    logic [31:0] perf_mul_cnt_q, perf_mul_cnt_d;
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

    always_comb begin
        perf_mul_cnt_d   = perf_mul_cnt_q;
        perf_stall_cnt_d = perf_stall_cnt_q;
        // Only results that are actually captured count; a flush in BUSY
        // discards the result even when mul_done arrives in the same cycle.
        if ((state_q == S_BUSY) && mul_done && !flush) begin
            perf_mul_cnt_d = perf_mul_cnt_q + 32'd1;
        end
        if (id_valid && !id_ready) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_mul_cnt_q   <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_mul_cnt_q   <= perf_mul_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_mul_cnt   = perf_mul_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ex_mul_issue.sv
// ----------------------------------------------------------------------------
// tb_ex_mul_issue
//
// Bench for ex_mul_issue with a behavioural multi-cycle multiplier
// (MUL_CYCLES = 2). Expected results are pushed into exp_q when ID hands over
// an instruction and popped when MEM takes a result.
// ----------------------------------------------------------------------------
module tb_ex_mul_issue;

  localparam int         DW         = 32;
  localparam int         RW         = 5;
  localparam int         EW         = DW + RW;
  localparam int         MUL_CYCLES = 2;
  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_MUL     = 8'h30;
  localparam logic [7:0] OP_MULH    = 8'h31;
  localparam logic [7:0] OP_MULHU   = 8'h33;
  localparam logic [7:0] OP_ADD     = 8'h01;
  localparam logic [7:0] OP_XOR     = 8'h05;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          flush;
  logic          id_valid;
  logic          id_ready;
  logic [7:0]    id_op;
  logic [DW-1:0] id_src_a, id_src_b, id_alu_res;
  logic [RW-1:0] id_rd;
  logic [7:0]    mul_op;
  logic [DW-1:0] mul_a, mul_b;
  logic          mul_done;
  logic [DW-1:0] mul_result;
  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] mem_result;
  logic [RW-1:0] mem_rd;
`ifdef EX_MUL_PERF_EN
  logic [31:0]   perf_mul_cnt, perf_stall_cnt;
`endif

  ex_mul_issue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_op      (id_op),
    .id_src_a   (id_src_a),
    .id_src_b   (id_src_b),
    .id_alu_res (id_alu_res),
    .id_rd      (id_rd),
    .mul_op     (mul_op),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_result (mem_result),
    .mem_rd     (mem_rd)
`ifdef EX_MUL_PERF_EN
    ,
    .perf_mul_cnt   (perf_mul_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference product, used by both the multiplier model and the scoreboard.
  function automatic logic [DW-1:0] mul_ref(input logic [7:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [63:0] ps, pu;
    ps = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    pu = {32'b0, a} * {32'b0, b};
    if (op == OP_MUL)       return ps[31:0];
    else if (op == OP_MULH) return ps[63:32];
    else                    return pu[63:32];
  endfunction

  function automatic logic is_mul(input logic [7:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
  endfunction

  // ---------------- multiplier model ----------------
  // Launches when idle and mul_op is not NOP; pulses done MUL_CYCLES cycles
  // after the cycle in which it saw the op.
  logic          m_busy, m_done, spur_done;
  int            m_rem;
  int            launches;
  logic [DW-1:0] m_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_rem    <= 0;
      m_res    <= '0;
      launches <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy && !m_done && mul_op != OP_NOP) begin
        m_busy   <= 1'b1;
        m_rem    <= MUL_CYCLES - 1;
        m_res    <= mul_ref(mul_op, mul_a, mul_b);
        launches <= launches + 1;
      end else if (m_busy) begin
        if (m_rem <= 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_rem <= m_rem - 1;
        end
      end
    end
  end

  assign mul_done   = m_done | spur_done;
  assign mul_result = m_res;

  // MEM ready: directed value or a random per-cycle value.
  logic mem_rdy_drv, rand_rdy_en, rand_rdy;
  always @(posedge clk) rand_rdy <= 1'($urandom_range(0, 1));
  assign mem_ready = rand_rdy_en ? rand_rdy : mem_rdy_drv;

  // ---------------- scoreboard / monitor ----------------
  logic [EW-1:0] exp_q[$];
  logic          inflight;
  logic          hold_prev;
  logic [DW-1:0] prev_res;
  logic [RW-1:0] prev_rd;
  int            exp_mul_cnt, exp_stall;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      inflight    = 1'b0;
      hold_prev   = 1'b0;
      exp_mul_cnt = 0;
      exp_stall   = 0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 64'(mem_valid), 64'd1);
        chk("hold_result", 64'(mem_result), 64'(prev_res));
        chk("hold_rd", 64'(mem_rd), 64'(prev_rd));
      end
      if (mul_done && inflight && !flush) exp_mul_cnt++;
      if (mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 64'd1, 64'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("sb_result", 64'(mem_result), 64'(e[DW-1:0]));
          chk("sb_rd", 64'(mem_rd), 64'(e[EW-1:DW]));
        end
        inflight = 1'b0;
      end else if (flush && inflight) begin
        void'(exp_q.pop_back());
        inflight = 1'b0;
      end
      if (id_valid && !id_ready) exp_stall++;
      if (id_valid && id_ready) begin
        exp_q.push_back({id_rd, is_mul(id_op) ? mul_ref(id_op, id_src_a, id_src_b) : id_alu_res});
        inflight = 1'b1;
      end
      hold_prev = mem_valid && !mem_ready && !flush;
      prev_res  = mem_result;
      prev_rd   = mem_rd;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] alu, input logic [RW-1:0] rd);
    int n;
    id_valid   = 1'b1;
    id_op      = op;
    id_src_a   = a;
    id_src_b   = b;
    id_alu_res = alu;
    id_rd      = rd;
    n = 0;
    while (!id_ready && n < 50) begin
      tick();
      n++;
    end
    chk("issue_timeout", 64'(n < 50), 64'd1);
    tick();
    id_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!mem_valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 64'(n < 40), 64'd1);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] op_tab [5] = '{OP_MUL, OP_MULH, OP_MULHU, OP_ADD, OP_XOR};

  // ---------------- stimulus ----------------
  initial begin
    int l0;
    rst_n = 1'b0;
    flush = 1'b0; id_valid = 1'b0; id_op = OP_NOP;
    id_src_a = '0; id_src_b = '0; id_alu_res = '0; id_rd = '0;
    spur_done = 1'b0; mem_rdy_drv = 1'b1; rand_rdy_en = 1'b0;
    #3;
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mul_op", 64'(mul_op), 64'(OP_NOP));
    chk("rst_mem_result", 64'(mem_result), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_id_ready", 64'(id_ready), 64'd1);

    // T1: OP_MUL 7 * -3, timing cycle by cycle
    id_valid = 1'b1; id_op = OP_MUL; id_src_a = 32'd7; id_src_b = 32'hFFFFFFFD; id_rd = 5'd5;
    chk("t1_ready_c0", 64'(id_ready), 64'd1);
    tick(); id_valid = 1'b0;
    chk("t1_mulop_c1", 64'(mul_op), 64'(OP_MUL));
    chk("t1_mul_a", 64'(mul_a), 64'd7);
    chk("t1_mul_b", 64'(mul_b), 64'hFFFFFFFD);
    chk("t1_ready_c1", 64'(id_ready), 64'd0);
    tick();
    chk("t1_mulop_c2", 64'(mul_op), 64'(OP_MUL));
    tick();
    chk("t1_mulop_c3", 64'(mul_op), 64'(OP_MUL));
    chk("t1_valid_c3", 64'(mem_valid), 64'd0);
    tick();
    chk("t1_mulop_c4", 64'(mul_op), 64'(OP_NOP));
    chk("t1_valid_c4", 64'(mem_valid), 64'd1);
    chk("t1_result_c4", 64'(mem_result), 64'hFFFFFFEB);
    chk("t1_rd_c4", 64'(mem_rd), 64'd5);
    tick();
    chk("t1_valid_c5", 64'(mem_valid), 64'd0);
    chk("t1_ready_c5", 64'(id_ready), 64'd1);

    // T5: asynchronous reset in the middle of BUSY
    issue(OP_MUL, 32'd3, 32'd4, 32'd0, 5'd7);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mul_op", 64'(mul_op), 64'(OP_NOP));
    chk("arst_mul_a", 64'(mul_a), 64'd0);
    chk("arst_mul_b", 64'(mul_b), 64'd0);
    chk("arst_mem_valid", 64'(mem_valid), 64'd0);
    chk("arst_mem_result", 64'(mem_result), 64'd0);
    chk("arst_mem_rd", 64'(mem_rd), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("arst_ready_after", 64'(id_ready), 64'd1);

    // T2: OP_MULHU, MEM stalls 5 cycles
    mem_rdy_drv = 1'b0;
    l0 = launches;
    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 5'd2);
    wait_valid("t2_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("t2_result_stable", 64'(mem_result), 64'hFFFFFFFE);
      chk("t2_mul_op_nop", 64'(mul_op), 64'(OP_NOP));
      chk("t2_valid_held", 64'(mem_valid), 64'd1);
      tick();
    end
    chk("t2_single_launch", 64'(launches), 64'(l0 + 1));
    mem_rdy_drv = 1'b1;
    tick();
    chk("t2_valid_drop", 64'(mem_valid), 64'd0);

    // T3: non-mul op passes ALU result through in cycle 1
    id_valid = 1'b1; id_op = OP_ADD; id_alu_res = 32'h1234; id_rd = 5'd3;
    id_src_a = 32'd9; id_src_b = 32'd9;
    chk("t3_mul_op_c0", 64'(mul_op), 64'(OP_NOP));
    tick(); id_valid = 1'b0;
    chk("t3_valid_c1", 64'(mem_valid), 64'd1);
    chk("t3_result_c1", 64'(mem_result), 64'h1234);
    chk("t3_mul_op_c1", 64'(mul_op), 64'(OP_NOP));
    tick();
    chk("t3_valid_c2", 64'(mem_valid), 64'd0);

    // T4: flush in cycle 2 of a mul, then OP_MULH
    id_valid = 1'b1; id_op = OP_MUL; id_src_a = 32'd5; id_src_b = 32'd6; id_rd = 5'd4;
    tick(); id_valid = 1'b0;
    tick();
    flush = 1'b1;
    chk("t4_ready_flush", 64'(id_ready), 64'd0);
    tick(); flush = 1'b0;
    chk("t4_drain_mul_op", 64'(mul_op), 64'(OP_NOP));
    chk("t4_drain_done", 64'(mul_done), 64'd1);
    chk("t4_drain_ready", 64'(id_ready), 64'd0);
    chk("t4_drain_valid", 64'(mem_valid), 64'd0);
    tick();
    chk("t4_ready_after", 64'(id_ready), 64'd1);
    chk("t4_valid_after", 64'(mem_valid), 64'd0);
    issue(OP_MULH, 32'hFFFFFFF9, 32'd3, 32'd0, 5'd9);
    wait_valid("t4_mulh_timeout");
    chk("t4_mulh_result", 64'(mem_result), 64'hFFFFFFFF);
    tick();

    // Spurious mul_done in IDLE is ignored
    spur_done = 1'b1;
    tick(); spur_done = 1'b0;
    chk("spur_valid", 64'(mem_valid), 64'd0);
    chk("spur_ready", 64'(id_ready), 64'd1);
    tick();
    chk("spur_valid2", 64'(mem_valid), 64'd0);

    // Random back-to-back traffic with random MEM backpressure
    rand_rdy_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      issue(op_tab[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
            RW'($urandom_range(0, 31)));
    end
    rand_rdy_en = 1'b0;
    mem_rdy_drv = 1'b1;
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        tick();
        n++;
      end
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    tick();

`ifdef EX_MUL_PERF_EN
    chk("perf_mul_cnt", 64'(perf_mul_cnt), 64'(exp_mul_cnt));
    chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(exp_stall));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
